// File: rtl/ac97_codec_responder.sv
// AC97 codec-side frame responder: decodes controller frames (register writes/reads, DAC samples) and transmits response frames.
// Latency: reg_wr/dac_valid one cycle after the last frame bit; ac97_sdata_in lags the sampled bit by one cycle.
// Backpressure: none; the block is paced entirely by the AC97 bit clock and never stalls.
//
// Ports:
//   ac97_bit_clock, reset          clock (rising edge) and synchronous active-high reset
//   ac97_synch, ac97_sdata_out     frame sync and serial data from the controller
//   ac97_sdata_in                  registered serial data back to the controller
//   codec_ready                    value placed in transmitted tag bit 15
//   adc_left, adc_right            capture samples sent in slots 3/4
//   dac_left, dac_right, dac_valid playback samples decoded from slots 3/4
//   reg_wr, reg_wr_addr/data       register-write strobe with address and data
//   frame_error, locked            sync-misalignment pulse and frame-lock status
module ac97_codec_responder #(
   parameter logic [15:0] VENDOR_ID1 = 16'h4144,
   parameter logic [15:0] VENDOR_ID2 = 16'h5370
) (
   input  logic        ac97_bit_clock,
   input  logic        reset,
   input  logic        ac97_synch,
   input  logic        ac97_sdata_out,
   output logic        ac97_sdata_in,
   input  logic        codec_ready,
   input  logic [19:0] adc_left,
   input  logic [19:0] adc_right,
   output logic [19:0] dac_left,
   output logic [19:0] dac_right,
   output logic        dac_valid,
   output logic        reg_wr,
   output logic [6:0]  reg_wr_addr,
   output logic [15:0] reg_wr_data,
   output logic        frame_error,
   output logic        locked
);

   typedef enum logic {UNLOCKED, FRAME} state_t;

   state_t      state, state_nxt;
   logic        sync_prev;
   logic        sync_rise;
   logic        synced;       // current frame was started by a sync rise
   logic [7:0]  bit_cnt;

   // Only tag + slots 1-4 (first 96 bits) carry anything we use; the
   // remaining 160 bits are ignored on receive and sent as zero.
   logic [95:0] rx_shift;
   logic [95:0] tx_shift;
   logic [95:0] tx_frame;

   logic        load_frame;
   logic        advance;
   logic        frame_done;
   logic        resync_err;

   logic        rd_pending;
   logic [6:0]  rd_index;
   logic        resp_sent;    // response for rd_pending is in the frame now being sent
   logic [15:0] rd_data;

   logic [15:0] regfile [64];

   logic [15:0] rx_tag;
   logic [19:0] rx_slot1, rx_slot2, rx_slot3, rx_slot4;
   logic        frame_vld;
   logic        vendor_idx;
   logic        wr_req, rd_req, play_l, play_r;
   logic        unused_rx;

   assign sync_rise = ac97_synch & ~sync_prev;
   assign locked    = (state == FRAME);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge ac97_bit_clock) begin
      if (reset) state <= UNLOCKED;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_frame = 1'b0;
      advance    = 1'b0;
      frame_done = 1'b0;
      resync_err = 1'b0;
      case (state)
         UNLOCKED: begin
            if (sync_rise) begin
               state_nxt  = FRAME;
               load_frame = 1'b1;
            end
         end
         FRAME: begin
            if (sync_rise) begin
               load_frame = 1'b1;
               resync_err = (bit_cnt != 8'd0);
            end else if (bit_cnt == 8'd255 && !synced) begin
               // A whole frame period passed since the wrap with no sync.
               state_nxt = UNLOCKED;
            end else begin
               advance    = 1'b1;
               frame_done = (bit_cnt == 8'd255);
            end
         end
      endcase
   end

   // ---------------------------------------------------------- decode
   assign rx_tag   = rx_shift[95:80];
   assign rx_slot1 = rx_shift[79:60];
   assign rx_slot2 = rx_shift[59:40];
   assign rx_slot3 = rx_shift[39:20];
   assign rx_slot4 = rx_shift[19:0];

   assign frame_vld  = frame_done & rx_tag[15];
   // index[6:2] all ones covers 7C..7F, the read-only vendor-ID pair and their odd aliases
   assign vendor_idx = (rx_slot1[18:14] == 5'h1F);
   assign wr_req     = frame_vld & rx_tag[14] & rx_tag[13] & ~rx_slot1[19] & ~vendor_idx;
   assign rd_req     = frame_vld & rx_tag[14] & rx_slot1[19];
   assign play_l     = frame_vld & rx_tag[12];
   assign play_r     = frame_vld & rx_tag[11];

   // Received fields that carry nothing this codec acts on.
   assign unused_rx = ^{rx_tag[10:0], rx_slot1[11:0], rx_slot2[3:0]};

   // ---------------------------------------------------------- transmit
   always_comb begin
      rd_data = regfile[rd_index[6:1]];
      if (rd_index[6:2] == 5'h1F) rd_data = rd_index[1] ? VENDOR_ID2 : VENDOR_ID1;
   end

   assign tx_frame = {codec_ready, rd_pending, rd_pending, 2'b11, 11'b0,
                      rd_pending ? {1'b0, rd_index, 12'h000} : 20'h0,
                      rd_pending ? {rd_data, 4'h0} : 20'h0,
                      adc_left, adc_right};

   // ---------------------------------------------------------- register file
   always_ff @(posedge ac97_bit_clock) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) regfile[i] <= 16'h0;
      end else if (wr_req) begin
         regfile[rx_slot1[18:13]] <= rx_slot2[19:4];
      end
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge ac97_bit_clock) begin
      if (reset) begin
         sync_prev     <= 1'b0;
         synced        <= 1'b0;
         bit_cnt       <= 8'd0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         ac97_sdata_in <= 1'b0;
         rd_pending    <= 1'b0;
         rd_index      <= 7'd0;
         resp_sent     <= 1'b0;
         dac_left      <= 20'h0;
         dac_right     <= 20'h0;
         dac_valid     <= 1'b0;
         reg_wr        <= 1'b0;
         reg_wr_addr   <= 7'd0;
         reg_wr_data   <= 16'h0;
         frame_error   <= 1'b0;
      end else begin
         sync_prev   <= ac97_synch;
         frame_error <= resync_err;
         reg_wr      <= wr_req;
         dac_valid   <= play_l | play_r;

         if (load_frame) begin
            // The bit sampled on the sync-rise cycle is frame bit 0.
            bit_cnt       <= 8'd1;
            synced        <= 1'b1;
            rx_shift      <= {95'b0, ac97_sdata_out};
            ac97_sdata_in <= tx_frame[95];
            tx_shift      <= {tx_frame[94:0], 1'b0};
            resp_sent     <= rd_pending;
         end else if (advance) begin
            bit_cnt <= bit_cnt + 8'd1;   // 255 wraps to 0
            if (bit_cnt < 8'd96) rx_shift <= {rx_shift[94:0], ac97_sdata_out};
            ac97_sdata_in <= tx_shift[95];
            tx_shift      <= {tx_shift[94:0], 1'b0};
            if (frame_done) begin
               synced    <= 1'b0;
               resp_sent <= 1'b0;
            end
         end else begin
            bit_cnt       <= 8'd0;
            ac97_sdata_in <= 1'b0;
         end

         if (wr_req) begin
            reg_wr_addr <= rx_slot1[18:12];
            reg_wr_data <= rx_slot2[19:4];
         end
         if (play_l) dac_left  <= rx_slot3;
         if (play_r) dac_right <= rx_slot4;

         // A new read request wins over clearing the one just answered.
         if (rd_req) begin
            rd_pending <= 1'b1;
            rd_index   <= rx_slot1[18:12];
         end else if (frame_done && resp_sent) begin
            rd_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ac97_codec_responder.sv
module tb_ac97_codec_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        synch;
   logic        sdata_out;
   logic        sdata_in;
   logic        codec_ready;
   logic [19:0] adc_left, adc_right;
   logic [19:0] dac_left, dac_right;
   logic        dac_valid, reg_wr, frame_error, locked;
   logic [6:0]  reg_wr_addr;
   logic [15:0] reg_wr_data;

   int total;
   int bad;

   // pulse monitor
   int          wr_cnt, dv_cnt, err_cnt, both_cnt;
   logic [6:0]  last_addr;
   logic [15:0] last_data;

   logic [95:0] txcap;   // first 96 transmitted bits of the last full frame sent

   always #5 clk = ~clk;

   ac97_codec_responder dut (
      .ac97_bit_clock (clk),
      .reset          (reset),
      .ac97_synch     (synch),
      .ac97_sdata_out (sdata_out),
      .ac97_sdata_in  (sdata_in),
      .codec_ready    (codec_ready),
      .adc_left       (adc_left),
      .adc_right      (adc_right),
      .dac_left       (dac_left),
      .dac_right      (dac_right),
      .dac_valid      (dac_valid),
      .reg_wr         (reg_wr),
      .reg_wr_addr    (reg_wr_addr),
      .reg_wr_data    (reg_wr_data),
      .frame_error    (frame_error),
      .locked         (locked)
   );

   always @(posedge clk) begin
      #1;
      if (reg_wr) begin
         wr_cnt++;
         last_addr = reg_wr_addr;
         last_data = reg_wr_data;
      end
      if (dac_valid) dv_cnt++;
      if (frame_error) err_cnt++;
      if (dac_valid && reg_wr) both_cnt++;
   end

   function automatic logic [95:0] mk(input logic [15:0] tag, input logic [19:0] s1,
                                      input logic [19:0] s2, input logic [19:0] s3,
                                      input logic [19:0] s4);
      return {tag, s1, s2, s3, s4};
   endfunction

   // Called and returns at a negedge. Sync is high for the first 16 bits.
   task automatic send_bits(input logic [95:0] f, input int nbits);
      for (int k = 0; k < nbits; k++) begin
         synch     = (k < 16);
         sdata_out = (k < 96) ? f[95-k] : 1'b0;
         @(posedge clk);
         #1;
         if (k < 96) txcap[95-k] = sdata_in;
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [95:0] f);
      send_bits(f, 256);
   endtask

   task automatic idle(input int n);
      synch     = 1'b0;
      sdata_out = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle(3);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
      total++; if (sdata_in !== 1'b0) begin bad++; $display("FAIL reset_sdata_in: got %b want 0", sdata_in); end
      total++; if ({reg_wr, dac_valid, frame_error} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {reg_wr, dac_valid, frame_error}); end
      total++; if ({dac_left, dac_right} !== 40'h0) begin bad++; $display("FAIL reset_dac: got %h want 0", {dac_left, dac_right}); end
      reset = 1'b0;
      idle(5);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_nolock_without_sync: got %b want 0", locked); end
   endtask

   task automatic test_write_read;
      int wr0;
      wr0 = wr_cnt;
      send_frame(mk(16'hE000, 20'h02000, 20'h08080, 20'h0, 20'h0));
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL wr_locked: got %b want 1", locked); end
      total++; if (wr_cnt - wr0 !== 1) begin bad++; $display("FAIL wr_count: got %0d want 1", wr_cnt - wr0); end
      total++; if (last_addr !== 7'h02) begin bad++; $display("FAIL wr_addr: got %h want 02", last_addr); end
      total++; if (last_data !== 16'h0808) begin bad++; $display("FAIL wr_data: got %h want 0808", last_data); end
      send_frame(mk(16'hC000, 20'h82000, 20'h0, 20'h0, 20'h0));
      send_frame(mk(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0));
      total++; if (txcap[95:80] !== 16'hF800) begin bad++; $display("FAIL rd_tag: got %h want f800", txcap[95:80]); end
      total++; if (txcap[79:60] !== 20'h02000) begin bad++; $display("FAIL rd_slot1: got %h want 02000", txcap[79:60]); end
      total++; if (txcap[59:40] !== 20'h08080) begin bad++; $display("FAIL rd_slot2: got %h want 08080", txcap[59:40]); end
      total++; if (err_cnt !== 0) begin bad++; $display("FAIL wr_no_error: got %0d want 0", err_cnt); end
   endtask

   task automatic test_vendor;
      int wr0;
      wr0 = wr_cnt;
      send_frame(mk(16'hE000, 20'h7C000, 20'h12340, 20'h0, 20'h0));  // ignored write
      send_frame(mk(16'hC000, 20'hFC000, 20'h0, 20'h0, 20'h0));      // read 7C
      send_frame(mk(16'hC000, 20'hFE000, 20'h0, 20'h0, 20'h0));      // read 7E
      total++; if (wr_cnt - wr0 !== 0) begin bad++; $display("FAIL vendor_no_wr: got %0d want 0", wr_cnt - wr0); end
      total++; if (txcap[79:60] !== 20'h7C000) begin bad++; $display("FAIL vid1_slot1: got %h want 7c000", txcap[79:60]); end
      total++; if (txcap[59:40] !== 20'h41440) begin bad++; $display("FAIL vid1_slot2: got %h want 41440", txcap[59:40]); end
      codec_ready = 1'b0;
      send_frame(mk(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0));
      total++; if (txcap[95:80] !== 16'h7800) begin bad++; $display("FAIL vid2_tag: got %h want 7800", txcap[95:80]); end
      total++; if (txcap[79:60] !== 20'h7E000) begin bad++; $display("FAIL vid2_slot1: got %h want 7e000", txcap[79:60]); end
      total++; if (txcap[59:40] !== 20'h53700) begin bad++; $display("FAIL vid2_slot2: got %h want 53700", txcap[59:40]); end
      codec_ready = 1'b1;
      send_frame(mk(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0));
      total++; if (txcap[95:80] !== 16'h9800) begin bad++; $display("FAIL pend_clear_tag: got %h want 9800", txcap[95:80]); end
      total++; if (txcap[79:40] !== 40'h0) begin bad++; $display("FAIL pend_clear_slots: got %h want 0", txcap[79:40]); end
   endtask

   task automatic test_playback;
      int dv0, both0;
      dv0 = dv_cnt;
      both0 = both_cnt;
      adc_left  = 20'h12345;
      adc_right = 20'h6789A;
      send_frame(mk(16'h9000, 20'h0, 20'h0, 20'hABCDE, 20'h0));
      total++; if (dac_left !== 20'hABCDE) begin bad++; $display("FAIL dac_left: got %h want abcde", dac_left); end
      total++; if (dac_right !== 20'h0) begin bad++; $display("FAIL dac_right_held: got %h want 0", dac_right); end
      total++; if (dv_cnt - dv0 !== 1) begin bad++; $display("FAIL dac_valid_width: got %0d want 1", dv_cnt - dv0); end
      total++; if (txcap[39:0] !== 40'h123456789A) begin bad++; $display("FAIL adc_slots: got %h want 123456789a", txcap[39:0]); end
      send_frame(mk(16'hE800, 20'h10000, 20'h0AAA0, 20'h0, 20'h55555));
      total++; if ({dac_left, dac_right} !== 40'hABCDE55555) begin bad++; $display("FAIL dac_right: got %h want abcde55555", {dac_left, dac_right}); end
      total++; if (both_cnt - both0 !== 1) begin bad++; $display("FAIL dac_with_wr: got %0d want 1", both_cnt - both0); end
      total++; if ({last_addr, last_data} !== {7'h10, 16'h0AAA}) begin bad++; $display("FAIL play_wr: got %h/%h want 10/0aaa", last_addr, last_data); end
   endtask

   task automatic test_resync;
      int wr0, err0;
      wr0 = wr_cnt;
      err0 = err_cnt;
      send_bits(mk(16'hE000, 20'h20000, 20'hBEEF0, 20'h0, 20'h0), 100);
      send_frame(mk(16'hE000, 20'h22000, 20'h12340, 20'h0, 20'h0));
      total++; if (err_cnt - err0 !== 1) begin bad++; $display("FAIL resync_error: got %0d want 1", err_cnt - err0); end
      total++; if (wr_cnt - wr0 !== 1) begin bad++; $display("FAIL resync_wr_count: got %0d want 1", wr_cnt - wr0); end
      total++; if ({last_addr, last_data} !== {7'h22, 16'h1234}) begin bad++; $display("FAIL resync_wr: got %h/%h want 22/1234", last_addr, last_data); end
   endtask

   task automatic test_sync_loss;
      int err0;
      err0 = err_cnt;
      idle(200);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_still_locked: got %b want 1", locked); end
      idle(100);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_unlocked: got %b want 0", locked); end
      total++; if (sdata_in !== 1'b0) begin bad++; $display("FAIL loss_sdata_in: got %b want 0", sdata_in); end
      total++; if (err_cnt - err0 !== 0) begin bad++; $display("FAIL loss_no_error: got %0d want 0", err_cnt - err0); end
   endtask

   task automatic test_reset_midframe;
      int wr0, dv0, err0;
      err0 = err_cnt;
      send_frame(mk(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0));
      total++; if (err_cnt - err0 !== 0) begin bad++; $display("FAIL relock_no_error: got %0d want 0", err_cnt - err0); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock: got %b want 1", locked); end
      wr0 = wr_cnt;
      dv0 = dv_cnt;
      send_bits(mk(16'hF000, 20'h30000, 20'h77770, 20'h11111, 20'h0), 120);
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(1);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_mid_locked: got %b want 0", locked); end
      total++; if (dac_left !== 20'h0) begin bad++; $display("FAIL rst_mid_dac: got %h want 0", dac_left); end
      idle(300);
      total++; if (wr_cnt - wr0 !== 0 || dv_cnt - dv0 !== 0) begin bad++; $display("FAIL rst_mid_pulses: got wr=%0d dv=%0d want 0/0", wr_cnt - wr0, dv_cnt - dv0); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_needs_sync: got %b want 0", locked); end
      send_frame(mk(16'hC000, 20'h82000, 20'h0, 20'h0, 20'h0));
      send_frame(mk(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0));
      total++; if (txcap[79:40] !== 40'h0200000000) begin bad++; $display("FAIL rst_regfile: got %h want 0200000000", txcap[79:40]); end
   endtask

   initial begin
      reset       = 1'b1;
      synch       = 1'b0;
      sdata_out   = 1'b0;
      codec_ready = 1'b1;
      adc_left    = 20'h0;
      adc_right   = 20'h0;
      @(negedge clk);
      test_reset;
      test_write_read;
      test_vendor;
      test_playback;
      test_resync;
      test_sync_loss;
      test_reset_midframe;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
